// File: rtl/uart_disp_pkg.sv
// Shared types and helpers for the UART receiver and hex display.
//   rx_state_e : receiver FSM states
//   SEG_BLANK  : lit pattern of an unlit digit, before polarity is applied
//   hex_to_seg : nibble -> lit pattern, bit order {G,F,E,D,C,B,A}
package uart_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: line synchroniser, start-bit glitch rejection,
// mid-bit sampling and framing-error detection.
//   i_Clk, i_Rst_L : clock, async active-low reset
//   i_RX_Serial    : asynchronous UART line, idle high
//   o_RX_Byte      : last good byte, held until the next good byte
//   o_RX_DV        : one-cycle pulse when o_RX_Byte updates
//   o_Frame_Err    : one-cycle pulse when the stop bit is sampled low
module uart_rx_core
  import uart_disp_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_Frame_Err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  // Last count of the start-bit wait (mid-bit) and of a full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_s;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       byte_n;
  logic             dv_n, err_n;

  // Two-flop synchroniser; resets to the idle level so reset never fakes a start.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_RX_Byte   <= '0;
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      o_RX_Byte   <= byte_n;
      o_RX_DV     <= dv_n;
      o_Frame_Err <= err_n;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    byte_n  = o_RX_Byte;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          // Line back high at mid-start: treat as a glitch.
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            byte_n = shift;
            dv_n   = 1'b1;
          end else begin
            err_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_hex_display.sv
// UART receiver driving a multi-digit hex seven-segment display.
// Keeps a history of NUM_BYTES received bytes, two digits per byte.
//   i_Clk, i_Rst_L : clock, async active-low reset
//   i_RX_Serial    : asynchronous UART line, idle high
//   i_Clear        : synchronous clear of the display history
//   o_RX_Byte      : last good byte received
//   o_RX_DV        : one-cycle pulse when o_RX_Byte updates
//   o_Frame_Err    : one-cycle pulse on a low stop bit
//   o_Segments     : digit d at [7*d +: 7], {G..A}; digit 0 = low nibble of newest byte
module uart_rx_hex_display
  import uart_disp_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 217,
  parameter int unsigned NUM_BYTES      = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_RX_Serial,
  input  logic                    i_Clear,
  output logic [7:0]              o_RX_Byte,
  output logic                    o_RX_DV,
  output logic                    o_Frame_Err,
  output logic [14*NUM_BYTES-1:0] o_Segments
);

  localparam int unsigned HIST_W = 8 * NUM_BYTES;
  localparam int unsigned SEG_W  = 14 * NUM_BYTES;
  localparam logic [6:0]  POL_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [NUM_BYTES-1:0][7:0] hist, hist_n, hist_base;
  logic [NUM_BYTES-1:0]      valid, valid_n, valid_base;
  logic [SEG_W-1:0]          seg_n;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_Byte   (o_RX_Byte),
    .o_RX_DV     (o_RX_DV),
    .o_Frame_Err (o_Frame_Err)
  );

  // Next history: clear first, then shift in a new byte, so a simultaneous
  // clear and new byte leaves only the new byte valid.
  always_comb begin
    hist_base  = i_Clear ? '0 : hist;
    valid_base = i_Clear ? '0 : valid;
    hist_n     = hist_base;
    valid_n    = valid_base;
    if (o_RX_DV) begin
      hist_n  = HIST_W'({hist_base, o_RX_Byte});
      valid_n = NUM_BYTES'({valid_base, 1'b1});
    end
  end

  // Decode from the next history so the display follows o_RX_DV by one cycle.
  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_dec
    assign seg_n[14*b +: 7] =
      (valid_n[b] ? hex_to_seg(hist_n[b][3:0]) : SEG_BLANK) ^ POL_MASK;
    assign seg_n[14*b+7 +: 7] =
      (valid_n[b] ? hex_to_seg(hist_n[b][7:4]) : SEG_BLANK) ^ POL_MASK;
  end

  // History, valid flags and segment registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hist       <= '0;
      valid      <= '0;
      o_Segments <= {SEG_W{SEG_ACTIVE_LOW}};
    end else begin
      hist       <= hist_n;
      valid      <= valid_n;
      o_Segments <= seg_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_hex_display.sv
module tb_uart_rx_hex_display;

  localparam int unsigned CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n, rx_a, rx_b, clr_a, clr_b;
  logic [7:0]  byte_a, byte_b;
  logic        dv_a, dv_b, err_a, err_b;
  logic [13:0] seg_a;
  logic [27:0] seg_b;

  int n_total = 0, n_pass = 0;
  int n_dv_a = 0, n_err_a = 0, n_dv_b = 0, n_err_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       seg_pend_a = 1'b0;
  logic [7:0] seg_byte_a = 8'h00;

  always #5 clk = ~clk;

  uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_a), .i_Clear(clr_a),
    .o_RX_Byte(byte_a), .o_RX_DV(dv_a), .o_Frame_Err(err_a), .o_Segments(seg_a));

  uart_rx_hex_display #(.CLKS_PER_BIT(CPB), .NUM_BYTES(2), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_b), .i_Clear(clr_b),
    .o_RX_Byte(byte_b), .o_RX_DV(dv_b), .o_Frame_Err(err_b), .o_Segments(seg_b));

  function automatic logic [6:0] lit(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111; 4'h1: s = 7'b0000110; 4'h2: s = 7'b1011011; 4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110; 4'h5: s = 7'b1101101; 4'h6: s = 7'b1111101; 4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111; 4'h9: s = 7'b1101111; 4'hA: s = 7'b1110111; 4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001; 4'hD: s = 7'b1011110; 4'hE: s = 7'b1111001; default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rx_b = v; else rx_a = v;
  endtask

  // One 8N1 frame. A bad stop bit is held low for half a bit, then the line idles.
  task automatic send(input bit which, input logic [7:0] b, input bit stop_ok, input bit clr_on_dv);
    set_line(which, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      set_line(which, b[k]);
      repeat (CPB) @(negedge clk);
    end
    set_line(which, stop_ok);
    if (stop_ok) begin
      if (which) q_b.push_back(b); else q_a.push_back(b);
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (clr_on_dv) clr_b = dv_b;
      end
      clr_b = 1'b0;
    end else begin
      repeat (CPB / 2) @(negedge clk);
      set_line(which, 1'b1);
      repeat (CPB / 2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  // Scoreboard: pop the expected byte on each data-valid pulse; for dut_a also
  // check the display one cycle after the pulse.
  initial forever begin
    logic [8:0] exp;
    @(negedge clk);
    if (seg_pend_a) begin
      chk("seg_latency_a", {18'h0, seg_a}, {18'h0, ~lit(seg_byte_a[7:4]), ~lit(seg_byte_a[3:0])});
      seg_pend_a = 1'b0;
    end
    if (dv_a === 1'b1) begin
      n_dv_a++;
      exp = 9'h000;
      if (q_a.size() != 0) begin
        exp = {1'b1, q_a.pop_front()};
        seg_byte_a = exp[7:0];
        seg_pend_a = 1'b1;
      end
      chk("rx_byte_a", {23'h0, 1'b1, byte_a}, {23'h0, exp});
    end
    if (dv_b === 1'b1) begin
      n_dv_b++;
      exp = 9'h000;
      if (q_b.size() != 0) exp = {1'b1, q_b.pop_front()};
      chk("rx_byte_b", {23'h0, 1'b1, byte_b}, {23'h0, exp});
    end
    if (err_a === 1'b1) n_err_a++;
    if (err_b === 1'b1) n_err_b++;
  end

  initial begin
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset_byte_a", {24'h0, byte_a}, 32'h0);
    chk("reset_dv_a", {31'h0, dv_a}, 32'h0);
    chk("reset_err_a", {31'h0, err_a}, 32'h0);
    chk("reset_seg_a", {18'h0, seg_a}, 32'h3FFF);
    chk("reset_seg_b", {4'h0, seg_b}, 32'h0);

    // Good frame 0x3C.
    send(1'b0, 8'h3C, 1'b1, 1'b0);
    chk("dv_count_3c", n_dv_a, 1);
    chk("byte_3c", {24'h0, byte_a}, 32'h3C);
    chk("seg_3c", {18'h0, seg_a}, {18'h0, 7'b0110000, 7'b1000110});

    // Frame 0xA5 with a low stop bit.
    send(1'b0, 8'hA5, 1'b0, 1'b0);
    chk("err_count_a5", n_err_a, 1);
    chk("dv_count_a5", n_dv_a, 1);
    chk("byte_held_a5", {24'h0, byte_a}, 32'h3C);
    chk("seg_held_a5", {18'h0, seg_a}, {18'h0, 7'b0110000, 7'b1000110});

    // Two-cycle start glitch, then a good frame.
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_dv_count", n_dv_a, 1);
    chk("glitch_err_count", n_err_a, 1);
    send(1'b0, 8'h01, 1'b1, 1'b0);
    chk("byte_01", {24'h0, byte_a}, 32'h01);
    chk("dv_count_01", n_dv_a, 2);
    chk("seg_01", {18'h0, seg_a}, {18'h0, 7'b1000000, 7'b1111001});

    // Two-byte history, active-high segments.
    send(1'b1, 8'h12, 1'b1, 1'b0);
    chk("seg_b_12", {4'h0, seg_b}, {4'h0, 14'h0, 7'b0000110, 7'b1011011});
    send(1'b1, 8'hEF, 1'b1, 1'b0);
    chk("seg_b_12_ef", {4'h0, seg_b},
        {4'h0, 7'b0000110, 7'b1011011, 7'b1111001, 7'b1110001});
    send(1'b1, 8'h7B, 1'b1, 1'b1);
    chk("seg_b_clear_with_7b", {4'h0, seg_b}, {4'h0, 14'h0, 7'b0000111, 7'b1111100});
    chk("byte_b_7b", {24'h0, byte_b}, 32'h7B);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("seg_b_cleared", {4'h0, seg_b}, 32'h0);
    chk("byte_b_after_clear", {24'h0, byte_b}, 32'h7B);
    chk("dv_count_b", n_dv_b, 3);
    chk("err_count_b", n_err_b, 0);

    // Reset during bit 4 of a frame, then a clean 0x55.
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx_a = k[0] ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx_a = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_dv_count", n_dv_a, 2);
    chk("abort_err_count", n_err_a, 1);
    chk("abort_byte", {24'h0, byte_a}, 32'h0);
    chk("abort_seg", {18'h0, seg_a}, 32'h3FFF);
    send(1'b0, 8'h55, 1'b1, 1'b0);
    chk("byte_55", {24'h0, byte_a}, 32'h55);
    chk("seg_55", {18'h0, seg_a}, {18'h0, 7'b0010010, 7'b0010010});
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_hex_display.md
Name: uart_rx_hex_display

Overview:
Parametrised UART receiver feeding a multi-digit hex seven-segment display. Received bytes enter a display history of NUM_BYTES bytes; each byte drives two digits (high nibble, low nibble). Adds glitch rejection on the start bit, framing-error detection, blanking of unwritten digits, selectable segment polarity and a synchronous display clear. Replaces the fixed single-byte, two-digit, active-low-only receive/display top in board designs.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (clock frequency / baud rate); legal range 4..65535.
NUM_BYTES, 1, bytes of history shown; legal range 1..4; drives 2*NUM_BYTES digits.
SEG_ACTIVE_LOW, 1, 1 = segment outputs driven low for lit; 0 = driven high for lit.

Ports:
i_Clk  in  1  system clock; only clock in the block.
i_Rst_L  in  1  asynchronous, active-low reset.
i_RX_Serial  in  1  UART line, asynchronous, idle high.
i_Clear  in  1  synchronous display clear; one-cycle pulse or level.
o_RX_Byte  out  8  last good byte received; holds until the next good byte.
o_RX_DV  out  1  one-cycle pulse when o_RX_Byte updates.
o_Frame_Err  out  1  one-cycle pulse when the stop bit is sampled low.
o_Segments  out  14*NUM_BYTES  digit d at [7*d +: 7], bit order {G,F,E,D,C,B,A}; digit 0 = low nibble of newest byte, digit 1 = high nibble of newest byte, digit 2 = low nibble of previous byte, and so on.

Behaviour:
- Reset (async assert, sync release): FSM IDLE; o_RX_Byte=0x00; o_RX_DV=0; o_Frame_Err=0; history bytes=0; slot-valid flags=0; every digit blank (all seven bits = SEG_ACTIVE_LOW).
- i_RX_Serial passes through a 2-flop synchroniser (sync line = rx_s), which adds 2 cycles of latency before FSM input. Synchroniser flops reset to 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: rx_s=0 -> START with counter cleared. Cycle t0 is the first cycle rx_s=0 is observed in IDLE.
- START: sample at t0+(CLKS_PER_BIT-1)/2 (integer division). If rx_s=0 -> DATA. If rx_s=1 -> IDLE (glitch rejected, no output pulse).
- DATA: 8 bits, LSB first. Bit k is sampled at the mid-start sample + (k+1)*CLKS_PER_BIT. After bit 7 -> STOP.
- STOP: sample at the mid-start sample + 9*CLKS_PER_BIT.
  - rx_s=1: next cycle o_RX_Byte = assembled byte and o_RX_DV=1 for exactly one cycle.
  - rx_s=0: next cycle o_Frame_Err=1 for one cycle. Byte discarded; o_RX_Byte and display unchanged.
  - Either way -> IDLE right after the stop sample. A back-to-back frame whose start edge arrives during the second half of the stop bit is accepted.
- Line held low after a frame error (break): the next IDLE cycle sees rx_s=0 and starts a new frame. A break therefore produces repeated frame errors, not a hang.
- History: in the o_RX_DV cycle, slot[i] <= slot[i-1] for i>0, slot[0] <= new byte, and valid flags shift the same way with valid[0]<=1.
- Segments: registered decode of history. o_Segments reflects the new byte one cycle after o_RX_DV (two-cycle latency from the stop sample). Digits of invalid slots are blank.
- Decoder: full hex 0-F, standard shapes (b and d lower-case). Lit pattern before polarity, {G..A}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - SEG_ACTIVE_LOW=1 inverts every bit.
- i_Clear: clears all valid flags and history bytes. Display is blank the following cycle.
  - o_RX_Byte is unaffected.
  - i_Clear and o_RX_DV in the same cycle: clear wins, then the new byte is written. Result: slot[0]=new byte, valid; other slots invalid.
- Reset mid-frame: FSM to IDLE immediately. The partial byte is lost and no pulses are produced.
- Counters are sized with $clog2(CLKS_PER_BIT). Bit index is 3 bits and wraps only via the state change.

Decomposition:
- Package uart_disp_pkg: state enum (IDLE/START/DATA/STOP), SEG_BLANK constant, hex-to-segment function returning the lit pattern in {G..A} order.
- Sub-module uart_rx_core: synchroniser, FSM, o_RX_Byte/o_RX_DV/o_Frame_Err. Parametrised by CLKS_PER_BIT only.
- Top level holds the history shift register, valid flags, clear logic and registered decode.

Test Plan:
- CLKS_PER_BIT=8, NUM_BYTES=1, SEG_ACTIVE_LOW=1: reset, then frame 0x3C with good stop bit -> one o_RX_DV pulse, o_RX_Byte=0x3C; next cycle o_Segments[13:7]=0110000 ('3'), [6:0]=1000110 ('C').
- Same config: frame 0xA5 with stop bit low -> one o_Frame_Err pulse, no o_RX_DV; o_RX_Byte stays 0x3C; segments unchanged.
- Same config: 2-cycle low glitch on an idle line -> no o_RX_DV, no o_Frame_Err, FSM back in IDLE; a following good frame 0x01 is received correctly.
- NUM_BYTES=2, SEG_ACTIVE_LOW=0: after reset, all 28 bits = 0; send 0x12 -> digits 3,2 blank, digits 1,0 = '1','2'; send 0xEF -> digits 3..0 = '1','2','E','F' (0000110, 1011011, 1111001, 1110001).
- NUM_BYTES=2: assert i_Clear in the same cycle as o_RX_DV for byte 0x7B -> digits 3,2 blank, digits 1,0 = '7','b'.
- Drop i_Rst_L during bit 4 of a frame, release, then send 0x55 -> no pulse for the aborted frame; o_RX_Byte=0x55 after the new frame; display shows only 0x55.
